pc_unit: RTL and testbench

//  Parametrised program-counter unit for the pipelined core: holds the fetch PC,

---
 rtl/pc_pkg.sv | 24 ++
 rtl/pc_unit_ras.sv | 50 +++++
 rtl/pc_unit.sv | 111 +++++++++++
 tb/tb_pc_unit.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter unit.
package pc_pkg;

    // PC value loaded on reset unless the instance overrides it.
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;

    // Next-PC source chosen for the coming edge.
    typedef enum logic [1:0] {
        PC_SEL_SEQ,
        PC_SEL_BRANCH,
        PC_SEL_JUMP,
        PC_SEL_TRAP
    } pc_sel_e;

    // Clears the low align_bits bits of an address (addresses up to 64 bits).
    function automatic logic [63:0] pc_align(input logic [63:0] addr,
                                             input int unsigned align_bits);
        logic [63:0] mask;
        mask = '1;
        mask = mask << align_bits;
        return addr & mask;
    endfunction

endpackage

// File: rtl/pc_unit_ras.sv
// Return-address stack: circular buffer of RAS_DEPTH entries with push, pop and
// replace-top. When full, a push overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned SIZE      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic            replace,
    input  logic [SIZE-1:0] data,
    output logic [SIZE-1:0] top,
    output logic            empty
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH) + 1;

    logic [SIZE-1:0]  entries [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count;

    // ptr names the next free slot; the top entry sits just below it (mod depth).
    assign top_idx = ptr - PTR_W'(1);
    assign empty   = (count == '0);
    assign top     = empty ? '0 : entries[top_idx];

    // Stack state update; replace on an empty stack degenerates to a push.
    always_ff @(posedge clk) begin
        if (reset) begin
            entries <= '{default: '0};
            ptr     <= '0;
            count   <= '0;
        end else if (push || (replace && empty)) begin
            entries[ptr] <= data;
            ptr          <= ptr + PTR_W'(1);
            if (count != CNT_W'(RAS_DEPTH)) begin
                count <= count + CNT_W'(1);
            end
        end else if (replace) begin
            entries[top_idx] <= data;
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit at the head of IF: fetch PC register, next-PC priority
// select (trap > stall > jump > branch > sequential), redirect alignment with a
// one-cycle misalignment flag, and a return-address stack for call/return.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     SIZE         = 32,
    parameter logic [SIZE-1:0] RESET_VECTOR = SIZE'(PC_RESET_VECTOR),
    parameter int unsigned     INSTR_BYTES  = 4,
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            STALL,
    input  logic            BRANCH_TAKEN,
    input  logic [SIZE-1:0] BRANCH_TARGET,
    input  logic            JUMP,
    input  logic [SIZE-1:0] JUMP_TARGET,
    input  logic            IS_CALL,
    input  logic            IS_RET,
    input  logic            TRAP,
    input  logic [SIZE-1:0] TRAP_VECTOR,
    output logic [SIZE-1:0] PC,
    output logic [SIZE-1:0] PC_PLUS,
    output logic [SIZE-1:0] RAS_TOP,
    output logic            RAS_EMPTY,
    output logic            MISALIGNED
);

    localparam int unsigned     ALIGN_BITS = $clog2(INSTR_BYTES);
    localparam logic [SIZE-1:0] LOW_MASK   = SIZE'(INSTR_BYTES - 1);

    pc_sel_e         sel;
    logic [SIZE-1:0] pc_q;
    logic [SIZE-1:0] pc_plus;
    logic [SIZE-1:0] redirect_target;
    logic [SIZE-1:0] next_pc;
    logic            next_misaligned;
    logic            misaligned_q;
    logic            ras_update;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_replace;

    assign pc_plus    = pc_q + SIZE'(INSTR_BYTES);
    assign PC         = pc_q;
    assign PC_PLUS    = pc_plus;
    assign MISALIGNED = misaligned_q;

    // Redirect source by priority; STALL is applied in the register block so TRAP can beat it.
    always_comb begin
        sel             = PC_SEL_SEQ;
        redirect_target = '0;
        if (TRAP) begin
            sel             = PC_SEL_TRAP;
            redirect_target = TRAP_VECTOR;
        end else if (JUMP) begin
            sel             = PC_SEL_JUMP;
            redirect_target = JUMP_TARGET;
        end else if (BRANCH_TAKEN) begin
            sel             = PC_SEL_BRANCH;
            redirect_target = BRANCH_TARGET;
        end
    end

    // Next PC: sequential increment, or the redirect target with its low bits cleared.
    always_comb begin
        next_pc         = pc_plus;
        next_misaligned = 1'b0;
        if (sel != PC_SEL_SEQ) begin
            next_pc         = SIZE'(pc_align(64'(redirect_target), ALIGN_BITS));
            next_misaligned = ((redirect_target & LOW_MASK) != '0);
        end
    end

    // PC register and misalignment pulse; a non-trap stall holds PC and clears the flag.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else if (STALL && !TRAP) begin
            misaligned_q <= 1'b0;
        end else begin
            pc_q         <= next_pc;
            misaligned_q <= next_misaligned;
        end
    end

    // RAS only moves on a live (non-stalled, non-trap) jump qualified as call and/or return.
    always_comb begin
        ras_update  = JUMP && !STALL && !TRAP;
        ras_push    = ras_update && IS_CALL && !IS_RET;
        ras_pop     = ras_update && IS_RET && !IS_CALL;
        ras_replace = ras_update && IS_CALL && IS_RET;
    end

    ras_stack #(
        .SIZE      (SIZE),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (CLK),
        .reset   (RESET),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .data    (pc_plus),
        .top     (RAS_TOP),
        .empty   (RAS_EMPTY)
    );

endmodule

// File: tb/tb_pc_unit.sv
// Directed scoreboard bench for pc_unit: each step queues the outputs expected
// after the next clock edge, and they are popped and compared 1 ns after it.
module tb_pc_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        STALL = 1'b0;
    logic        BRANCH_TAKEN = 1'b0;
    logic [31:0] BRANCH_TARGET = '0;
    logic        JUMP = 1'b0;
    logic [31:0] JUMP_TARGET = '0;
    logic        IS_CALL = 1'b0;
    logic        IS_RET = 1'b0;
    logic        TRAP = 1'b0;
    logic [31:0] TRAP_VECTOR = '0;
    logic [31:0] PC;
    logic [31:0] PC_PLUS;
    logic [31:0] RAS_TOP;
    logic        RAS_EMPTY;
    logic        MISALIGNED;

    pc_unit #(
        .SIZE         (32),
        .RESET_VECTOR (32'h0000_0000),
        .INSTR_BYTES  (4),
        .RAS_DEPTH    (4)
    ) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .STALL         (STALL),
        .BRANCH_TAKEN  (BRANCH_TAKEN),
        .BRANCH_TARGET (BRANCH_TARGET),
        .JUMP          (JUMP),
        .JUMP_TARGET   (JUMP_TARGET),
        .IS_CALL       (IS_CALL),
        .IS_RET        (IS_RET),
        .TRAP          (TRAP),
        .TRAP_VECTOR   (TRAP_VECTOR),
        .PC            (PC),
        .PC_PLUS       (PC_PLUS),
        .RAS_TOP       (RAS_TOP),
        .RAS_EMPTY     (RAS_EMPTY),
        .MISALIGNED    (MISALIGNED)
    );

    always #5 CLK = ~CLK;

    localparam int K_PC    = 0;
    localparam int K_PLUS  = 1;
    localparam int K_TOP   = 2;
    localparam int K_EMPTY = 3;
    localparam int K_MIS   = 4;

    string       tag_q [$];
    int          kind_q [$];
    logic [31:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_PC:    return PC;
            K_PLUS:  return PC_PLUS;
            K_TOP:   return RAS_TOP;
            K_EMPTY: return {31'b0, RAS_EMPTY};
            default: return {31'b0, MISALIGNED};
        endcase
    endfunction

    task automatic expect_out(input string tag, input int kind, input logic [31:0] value);
        tag_q.push_back(tag);
        kind_q.push_back(kind);
        exp_q.push_back(value);
    endtask

    task automatic score();
        while (exp_q.size() > 0) begin
            string       t;
            int          k;
            logic [31:0] e;
            logic [31:0] o;
            t = tag_q.pop_front();
            k = kind_q.pop_front();
            e = exp_q.pop_front();
            o = observe(k);
            checks++;
            assert (o === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", t, o, e);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        score();
    endtask

    task automatic clr();
        RESET         = 1'b0;
        STALL         = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = '0;
        JUMP          = 1'b0;
        JUMP_TARGET   = '0;
        IS_CALL       = 1'b0;
        IS_RET        = 1'b0;
        TRAP          = 1'b0;
        TRAP_VECTOR   = '0;
    endtask

    initial begin
        logic [31:0] ret_addr [4];
        ret_addr = '{32'h44, 32'h34, 32'h24, 32'h14};

        // 1: reset held two cycles, then sequential stepping
        clr();
        RESET = 1'b1;
        tick();
        expect_out("rst_pc", K_PC, 32'h0);
        expect_out("rst_empty", K_EMPTY, 32'h1);
        expect_out("rst_top", K_TOP, 32'h0);
        expect_out("rst_mis", K_MIS, 32'h0);
        expect_out("rst_plus", K_PLUS, 32'h4);
        tick();
        RESET = 1'b0;
        expect_out("seq_4", K_PC, 32'h4);
        tick();
        expect_out("seq_8", K_PC, 32'h8);
        tick();
        expect_out("seq_c", K_PC, 32'hC);
        tick();
        expect_out("seq_10", K_PC, 32'h10);
        tick();

        // 2: priority
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h40;
        JUMP = 1'b1; JUMP_TARGET = 32'h80;
        expect_out("jump_over_branch", K_PC, 32'h80);
        expect_out("jump_over_branch_mis", K_MIS, 32'h0);
        tick();
        clr();
        TRAP = 1'b1; TRAP_VECTOR = 32'h200; STALL = 1'b1;
        JUMP = 1'b1; JUMP_TARGET = 32'h80; IS_CALL = 1'b1;
        expect_out("trap_over_stall", K_PC, 32'h200);
        expect_out("trap_call_no_push", K_EMPTY, 32'h1);
        tick();
        clr();
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_out("stall_hold", K_PC, 32'h200);
            tick();
        end
        clr();
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h300;
        expect_out("branch", K_PC, 32'h300);
        tick();
        clr();

        // 3: misaligned redirects
        JUMP = 1'b1; JUMP_TARGET = 32'h103;
        expect_out("mis_jump_pc", K_PC, 32'h100);
        expect_out("mis_jump_flag", K_MIS, 32'h1);
        tick();
        clr();
        expect_out("mis_pulse_pc", K_PC, 32'h104);
        expect_out("mis_pulse_end", K_MIS, 32'h0);
        tick();
        JUMP = 1'b1; JUMP_TARGET = 32'h105;
        expect_out("mis_jump2_pc", K_PC, 32'h104);
        expect_out("mis_jump2_flag", K_MIS, 32'h1);
        tick();
        clr();
        STALL = 1'b1;
        expect_out("stall_clears_mis_pc", K_PC, 32'h104);
        expect_out("stall_clears_mis", K_MIS, 32'h0);
        tick();
        TRAP = 1'b1; TRAP_VECTOR = 32'h202;
        expect_out("mis_trap_pc", K_PC, 32'h200);
        expect_out("mis_trap_flag", K_MIS, 32'h1);
        tick();
        clr();

        // 4: RAS overflow with five calls, then pops
        RESET = 1'b1;
        expect_out("rst2_pc", K_PC, 32'h0);
        expect_out("rst2_empty", K_EMPTY, 32'h1);
        tick();
        clr();
        for (int k = 0; k < 5; k++) begin
            JUMP = 1'b1; IS_CALL = 1'b1; JUMP_TARGET = 32'(16 * (k + 1));
            expect_out("call_pc", K_PC, 32'(16 * (k + 1)));
            expect_out("call_top", K_TOP, 32'(16 * k + 4));
            expect_out("call_empty", K_EMPTY, 32'h0);
            tick();
        end
        clr();
        for (int i = 0; i < 4; i++) begin
            expect_out("pop_top", K_TOP, ret_addr[i]);
            score();
            JUMP = 1'b1; IS_RET = 1'b1; JUMP_TARGET = ret_addr[i];
            expect_out("ret_pc", K_PC, ret_addr[i]);
            tick();
        end
        expect_out("drained_empty", K_EMPTY, 32'h1);
        expect_out("drained_top", K_TOP, 32'h0);
        score();
        JUMP = 1'b1; IS_RET = 1'b1; JUMP_TARGET = 32'h60;
        expect_out("pop_empty_pc", K_PC, 32'h60);
        expect_out("pop_empty_empty", K_EMPTY, 32'h1);
        expect_out("pop_empty_top", K_TOP, 32'h0);
        tick();
        clr();

        // 5: call+ret in one cycle, and RAS immunity to trap/stall/unqualified call
        JUMP = 1'b1; JUMP_TARGET = 32'h40;
        expect_out("plain_jump_pc", K_PC, 32'h40);
        expect_out("plain_jump_empty", K_EMPTY, 32'h1);
        tick();
        IS_CALL = 1'b1; JUMP_TARGET = 32'h50;
        expect_out("call1_pc", K_PC, 32'h50);
        expect_out("call1_top", K_TOP, 32'h44);
        tick();
        IS_RET = 1'b1; JUMP_TARGET = 32'h90;
        expect_out("callret_pc", K_PC, 32'h90);
        expect_out("callret_top", K_TOP, 32'h54);
        expect_out("callret_empty", K_EMPTY, 32'h0);
        tick();
        clr();
        TRAP = 1'b1; TRAP_VECTOR = 32'h200;
        JUMP = 1'b1; IS_CALL = 1'b1; JUMP_TARGET = 32'h80;
        expect_out("trap_call_pc", K_PC, 32'h200);
        expect_out("trap_call_top", K_TOP, 32'h54);
        tick();
        clr();
        IS_CALL = 1'b1;
        expect_out("call_nojump_pc", K_PC, 32'h204);
        expect_out("call_nojump_top", K_TOP, 32'h54);
        tick();
        clr();
        STALL = 1'b1; JUMP = 1'b1; IS_RET = 1'b1; JUMP_TARGET = 32'h54;
        expect_out("stall_ret_pc", K_PC, 32'h204);
        expect_out("stall_ret_top", K_TOP, 32'h54);
        expect_out("stall_ret_empty", K_EMPTY, 32'h0);
        tick();
        clr();
        JUMP = 1'b1; IS_RET = 1'b1; JUMP_TARGET = 32'h54;
        expect_out("final_ret_pc", K_PC, 32'h54);
        expect_out("final_ret_empty", K_EMPTY, 32'h1);
        expect_out("final_ret_top", K_TOP, 32'h0);
        tick();
        clr();

        // 6: wrap-around and reset during a call
        JUMP = 1'b1; JUMP_TARGET = 32'hFFFF_FFFC;
        expect_out("max_pc", K_PC, 32'hFFFF_FFFC);
        expect_out("max_plus_wrap", K_PLUS, 32'h0);
        tick();
        clr();
        expect_out("wrap_pc", K_PC, 32'h0);
        expect_out("wrap_plus", K_PLUS, 32'h4);
        tick();
        JUMP = 1'b1; IS_CALL = 1'b1; JUMP_TARGET = 32'h80;
        expect_out("pre_rst_call_pc", K_PC, 32'h80);
        expect_out("pre_rst_call_top", K_TOP, 32'h4);
        tick();
        RESET = 1'b1; JUMP_TARGET = 32'h300;
        expect_out("rst_call_pc", K_PC, 32'h0);
        expect_out("rst_call_empty", K_EMPTY, 32'h1);
        expect_out("rst_call_top", K_TOP, 32'h0);
        expect_out("rst_call_mis", K_MIS, 32'h0);
        tick();
        clr();
        JUMP = 1'b1; IS_CALL = 1'b1; IS_RET = 1'b1; JUMP_TARGET = 32'h10;
        expect_out("callret_empty_pc", K_PC, 32'h10);
        expect_out("callret_empty_top", K_TOP, 32'h4);
        expect_out("callret_empty_flag", K_EMPTY, 32'h0);
        tick();
        clr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
